// File: rtl/fixed_div_unit_if.sv
// Operand/result handshake bundle for fixed_div_unit: valid/ready on both the issue and result sides.
interface fixed_div_unit_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_data;
  logic [WIDTH-1:0] b_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             div_by_zero;
  logic             overflow;

  modport slave (
    input  in_valid, a_data, b_data, out_ready,
    output in_ready, out_valid, out_data, div_by_zero, overflow
  );

  modport master (
    output in_valid, a_data, b_data, out_ready,
    input  in_ready, out_valid, out_data, div_by_zero, overflow
  );
endinterface

// File: rtl/fixed_div_unit.sv
// Signed fixed-point restoring divider, one quotient bit per cycle; result ITER cycles after accept (b==0: next cycle).
// Result holds in DONE until out_ready; no operands are taken outside IDLE.
module fixed_div_unit #(
  parameter int WIDTH     = 64,
  parameter int FRAC_BITS = 32
) (
  input logic             clk,
  input logic             reset,
  fixed_div_unit_if.slave div_if
);
  localparam int ITER  = WIDTH + FRAC_BITS;
  localparam int CNT_W = $clog2(ITER + 1);

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [ITER-1:0]  POS_LIM = {{(FRAC_BITS+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [ITER-1:0]  NEG_LIM = {{FRAC_BITS{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             qneg_q, qneg_d;
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic [ITER-1:0]  dvd_q, dvd_d;
  logic [ITER-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] amag;
  logic [WIDTH-1:0] bmag_in;
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [ITER-1:0]  quo_nxt;

  assign div_if.in_ready    = (state_q == IDLE);
  assign div_if.out_valid   = (state_q == DONE);
  assign div_if.out_data    = res_q;
  assign div_if.div_by_zero = dbz_q;
  assign div_if.overflow    = ovf_q;

  always_comb begin
    state_d = state_q;
    qneg_d  = qneg_q;
    bmag_d  = bmag_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    // Unsigned WIDTH-bit magnitudes still represent 2^(WIDTH-1) for the most negative operand.
    amag    = div_if.a_data[WIDTH-1] ? -div_if.a_data : div_if.a_data;
    bmag_in = div_if.b_data[WIDTH-1] ? -div_if.b_data : div_if.b_data;

    // Partial remainder stays below |b| <= 2^(WIDTH-1), so one extra bit covers the shift.
    rem_sh  = {rem_q, dvd_q[ITER-1]};
    rem_ge  = (rem_sh >= {1'b0, bmag_q});
    quo_nxt = {quo_q[ITER-2:0], rem_ge};

    case (state_q)
      IDLE: begin
        if (div_if.in_valid) begin
          qneg_d = div_if.a_data[WIDTH-1] ^ div_if.b_data[WIDTH-1];
          bmag_d = bmag_in;
          dvd_d  = {amag, {FRAC_BITS{1'b0}}};
          quo_d  = '0;
          rem_d  = '0;
          if (div_if.b_data == '0) begin
            dbz_d   = 1'b1;
            ovf_d   = 1'b0;
            res_d   = div_if.a_data[WIDTH-1] ? SAT_MIN : SAT_MAX;
            state_d = DONE;
          end else begin
            cnt_d   = CNT_W'(ITER);
            state_d = CALC;
          end
        end
      end

      CALC: begin
        rem_d = WIDTH'(rem_ge ? (rem_sh - {1'b0, bmag_q}) : rem_sh);
        dvd_d = dvd_q << 1;
        quo_d = quo_nxt;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          dbz_d   = 1'b0;
          state_d = DONE;
          if (!qneg_q) begin
            if (quo_nxt > POS_LIM) begin
              res_d = SAT_MAX;
              ovf_d = 1'b1;
            end else begin
              res_d = quo_nxt[WIDTH-1:0];
              ovf_d = 1'b0;
            end
          end else begin
            // Negating a zero magnitude yields plain zero, so -0 never appears.
            if (quo_nxt > NEG_LIM) begin
              res_d = SAT_MIN;
              ovf_d = 1'b1;
            end else begin
              res_d = -quo_nxt[WIDTH-1:0];
              ovf_d = 1'b0;
            end
          end
        end
      end

      DONE: begin
        if (div_if.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      qneg_q  <= 1'b0;
      bmag_q  <= '0;
      dvd_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      qneg_q  <= qneg_d;
      bmag_q  <= bmag_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: doc/fixed_div_unit.md
Name: fixed_div_unit

Overview:
- Iterative signed fixed-point divider alongside the Fpu datapath (Q32.32, 64-bit).
- The FPU issue logic sends division operands here instead of using a combinational divide, and writes the registered quotient back into the FPU result path.
- Computes quotient = (a << FRAC_BITS) / b with one quotient bit per cycle, valid/ready handshakes on both sides, saturation and divide-by-zero reporting.

Parameters:
- WIDTH, 64, operand/result width in bits (two's complement).
- FRAC_BITS, 32, fractional bits of the fixed-point format; ITER = WIDTH + FRAC_BITS iterations per divide.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  unit can accept operands.
- a_data  input  WIDTH  signed dividend, Q(WIDTH-FRAC_BITS).FRAC_BITS.
- b_data  input  WIDTH  signed divisor, same format.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  signed quotient, same format.
- div_by_zero  output  1  qualifier for out_data: b was zero.
- overflow  output  1  qualifier for out_data: quotient saturated.

Behaviour:
- Reset (async, any state): state=IDLE; out_valid=0, out_data=0, div_by_zero=0, overflow=0; in_ready=1 once reset deasserts; any in-flight divide is discarded.
- States: IDLE, CALC, DONE. in_ready = (state==IDLE), combinational from state only.
- IDLE:
  - On edge with in_valid&in_ready, latch sign_q = a[MSB]^b[MSB], sign_a = a[MSB], |a|, |b| (WIDTH+1-bit magnitudes, so that -2^(WIDTH-1) is handled).
  - Load dividend register = |a| << FRAC_BITS (ITER bits) and remainder = 0.
  - If b==0, go to DONE directly. Otherwise load counter = ITER and go to CALC.
- CALC (restoring division, MSB first):
  - Each edge: remainder = {remainder, next dividend bit}. If remainder >= |b|, subtract |b| and shift in quotient bit 1, else shift in 0.
  - Counter decrements each edge. On the edge where the counter goes 1->0, register the final result and go to DONE.
  - Inputs are ignored in CALC; a_data and b_data need not stay stable after acceptance.
- Latency:
  - Normal divide: out_valid rises ITER cycles after the accepting edge (96 with defaults).
  - b==0: out_valid rises 1 cycle after the accepting edge.
- Result rules (truncate toward zero):
  - Magnitude m is the ITER-bit quotient.
  - sign_q=0: if m > 2^(WIDTH-1)-1, out_data = 0x7FFF..F and overflow=1; else out_data = m.
  - sign_q=1: if m > 2^(WIDTH-1), out_data = 0x800..0 and overflow=1; else out_data = -m. m = 2^(WIDTH-1) is exact and sets no overflow.
  - A zero quotient is never negative-signed: -0 yields 0.
  - b==0: div_by_zero=1, overflow=0. out_data = 0x7FFF..F if sign_a=0 (including a==0), else 0x800..0.
- DONE:
  - out_valid=1. out_data, div_by_zero and overflow stay stable until the handshake.
  - On edge with out_valid&out_ready, go to IDLE with out_valid=0. Flags hold their last values but are only meaningful while out_valid=1.
  - out_ready held low stalls indefinitely with no change to outputs.
  - No new operands are accepted in DONE; the next accept is the earliest edge after returning to IDLE.
- Non-idle states always exit: no stuck states, and illegal state encodings recover to IDLE.

Test Plan:
- 3.0/2.0: a=0x0000_0003_0000_0000, b=0x0000_0002_0000_0000 -> out_valid exactly 96 cycles after accept; out_data=0x0000_0001_8000_0000; div_by_zero=0, overflow=0.
- Signs and truncation:
  - -3.0/2.0 -> 0xFFFF_FFFE_8000_0000.
  - 1.0/3.0 (a=0x0000_0001_0000_0000, b=0x0000_0003_0000_0000) -> 0x0000_0000_5555_5555.
  - -1.0/3.0 -> 0xFFFF_FFFF_AAAA_AAAB (truncation toward zero).
- Divide by zero:
  - a=0x0000_0005_0000_0000, b=0 -> out_valid 1 cycle after accept; out_data=0x7FFF_FFFF_FFFF_FFFF; div_by_zero=1.
  - a=-1.0, b=0 -> 0x8000_0000_0000_0000.
- Saturation boundaries:
  - a=0x4000_0000_0000_0000, b=0x0000_0000_0000_0001 -> 0x7FFF_FFFF_FFFF_FFFF, overflow=1.
  - a=0x8000_0000_0000_0000, b=0x0000_0001_0000_0000 -> 0x8000_0000_0000_0000, overflow=0.
  - a=0x8000_0000_0000_0000, b=0xFFFF_FFFF_0000_0000 (-1.0) -> 0x7FFF_FFFF_FFFF_FFFF, overflow=1.
- Backpressure and handshake:
  - Hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0, in_valid pulses ignored.
  - Raise out_ready -> IDLE next edge; back-to-back second divide gives the correct independent result.
- Reset mid-operation:
  - Assert reset at iteration 40 of a divide -> out_valid=0 and in_ready=1 immediately (async), with no spurious output.
  - The next divide after reset produces the correct result.
